// File: rtl/param_readback_serializer.sv
// param_readback_serializer
//   Snapshots the stored perceptron parameter bytes and streams them out as a framed
//   byte sequence over a valid/ready interface: header byte, then every neuron's
//   weights, bias and threshold (neuron 0 first).
//   Optional feature macro: READBACK_CSUM_EN appends an XOR checksum byte to each frame.
//   Without the macro the frame ends on the last payload byte.
module param_readback_serializer #(
  parameter int         NUM_NEURONS = 4,
  parameter int         NUM_INPUTS  = 4,
  parameter logic [7:0] HEADER_BYTE = 8'hA5
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic [NUM_NEURONS*(NUM_INPUTS+2)*8-1:0]   params_flat,
  input  logic                                      start,
  input  logic                                      out_ready,
  output logic [7:0]                                out_data,
  output logic                                      out_valid,
  output logic                                      out_last,
  output logic                                      busy,
  output logic                                      done
);

  localparam int BPN   = NUM_INPUTS + 2;
  localparam int TOTAL = NUM_NEURONS * BPN;
  localparam int CNT_W = $clog2(TOTAL + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TOTAL - 1);

`ifdef READBACK_CSUM_EN
  typedef enum logic [1:0] {ST_IDLE, ST_HDR, ST_PAYLOAD, ST_CSUM} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_HDR, ST_PAYLOAD} state_t;
`endif

  state_t           state, state_nxt;
  logic [7:0]       snap [TOTAL];
  logic [CNT_W-1:0] cnt;
  logic             done_q;
  logic             hs;
  logic             take;
  logic             pay_end;

`ifdef READBACK_CSUM_EN
  logic [7:0]       csum;
`endif

  // A byte moves on valid&&ready; a new frame is only accepted from IDLE.
  assign hs      = out_valid && out_ready;
  assign take    = (state == ST_IDLE) && start;
  assign pay_end = (state == ST_PAYLOAD) && (cnt == CNT_LAST);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic: each state advances only when its byte is accepted.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (start) state_nxt = ST_HDR;
      ST_HDR:     if (hs)    state_nxt = ST_PAYLOAD;
`ifdef READBACK_CSUM_EN
      ST_PAYLOAD: if (hs && pay_end) state_nxt = ST_CSUM;
      ST_CSUM:    if (hs)    state_nxt = ST_IDLE;
`else
      ST_PAYLOAD: if (hs && pay_end) state_nxt = ST_IDLE;
`endif
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // Output decode: every output depends only on registered state, so no input-to-output paths.
  always_comb begin
    out_data  = 8'h00;
    out_valid = 1'b0;
    out_last  = 1'b0;
    busy      = 1'b0;
    case (state)
      ST_HDR: begin
        out_data  = HEADER_BYTE;
        out_valid = 1'b1;
        busy      = 1'b1;
      end
      ST_PAYLOAD: begin
        out_data  = snap[cnt];
        out_valid = 1'b1;
        busy      = 1'b1;
`ifndef READBACK_CSUM_EN
        out_last  = pay_end;
`endif
      end
`ifdef READBACK_CSUM_EN
      ST_CSUM: begin
        out_data  = csum;
        out_valid = 1'b1;
        out_last  = 1'b1;
        busy      = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  // Parameter snapshot: captured once at frame start so later host writes cannot tear the frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < TOTAL; k++) snap[k] <= 8'h00;
    end else if (take) begin
      for (int k = 0; k < TOTAL; k++) snap[k] <= params_flat[8*k +: 8];
    end
  end

  // Payload byte counter: cleared at frame start, stops at the terminal count (state exits there).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                cnt <= '0;
    else if (take)                             cnt <= '0;
    else if (hs && (state == ST_PAYLOAD) && !pay_end) cnt <= cnt + 1'b1;
  end

`ifdef READBACK_CSUM_EN
  // Running XOR of accepted payload bytes, presented as the closing byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              csum <= 8'h00;
    else if (take)                           csum <= 8'h00;
    else if (hs && (state == ST_PAYLOAD))    csum <= csum ^ snap[cnt];
  end
`endif

  // Completion pulse: one cycle after the final byte is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) done_q <= 1'b0;
    else        done_q <= hs && out_last;
  end

  assign done = done_q;

endmodule

// File: tb/tb_param_readback_serializer.sv
// Scoreboard bench for param_readback_serializer: stimulus pushes the expected frame
// computed from the parameter vector; a negedge monitor checks every accepted byte,
// stall stability and the done/busy behaviour.
module tb_param_readback_serializer;

  localparam int NN    = 4;
  localparam int NI    = 4;
  localparam int TOTAL = NN * (NI + 2);
  localparam int PW    = TOTAL * 8;
`ifdef READBACK_CSUM_EN
  localparam int FLEN  = TOTAL + 2;
`else
  localparam int FLEN  = TOTAL + 1;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [PW-1:0] params_flat = '0;
  logic          start = 1'b0;
  logic          out_ready = 1'b1;
  logic [7:0]    out_data;
  logic          out_valid, out_last, busy, done;

  int n_checks = 0;
  int n_fail   = 0;
  int hs_count = 0;
  bit rand_ready = 0;
  logic [8:0] exp_q[$];   // {last, data}

  param_readback_serializer #(.NUM_NEURONS(NN), .NUM_INPUTS(NI), .HEADER_BYTE(8'hA5)) dut (
    .clk(clk), .rst_n(rst_n), .params_flat(params_flat), .start(start),
    .out_ready(out_ready), .out_data(out_data), .out_valid(out_valid),
    .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Reference model: the frame is the header, the parameter bytes in index order and optionally their XOR.
  task automatic push_frame(input logic [PW-1:0] p);
    logic [7:0] x;
    x = 8'h00;
    exp_q.push_back({1'b0, 8'hA5});
    for (int k = 0; k < TOTAL; k++) begin
      x ^= p[8*k +: 8];
`ifdef READBACK_CSUM_EN
      exp_q.push_back({1'b0, p[8*k +: 8]});
`else
      exp_q.push_back({(k == TOTAL - 1), p[8*k +: 8]});
`endif
    end
`ifdef READBACK_CSUM_EN
    exp_q.push_back({1'b1, x});
`endif
  endtask

  // Monitor: one negedge before each rising edge, so what it sees is what the edge will transfer.
  bit         prev_stall = 0;
  logic [7:0] prev_data;
  logic       prev_last;
  bit         expect_done = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall  = 0;
      expect_done = 0;
    end else begin
      if (expect_done) begin
        check("done_pulse", done, 1'b1);
        check("busy_after_done", busy, 1'b0);
        check("valid_after_done", out_valid, 1'b0);
        expect_done = 0;
      end else begin
        check("done_idle", done, 1'b0);
      end
      if (out_valid) check("busy_while_valid", busy, 1'b1);
      if (prev_stall) begin
        check("stall_valid", out_valid, 1'b1);
        check("stall_data", out_data, prev_data);
        check("stall_last", out_last, prev_last);
      end
      if (out_valid && out_ready) begin
        hs_count++;
        if (exp_q.size() == 0) begin
          check("unexpected_byte", {out_last, out_data}, 9'h000);
        end else begin
          logic [8:0] e;
          e = exp_q.pop_front();
          check("frame_byte", out_data, e[7:0]);
          check("frame_last", out_last, e[8]);
        end
        if (out_last) expect_done = 1;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
    end
  end

  // Background sink: random backpressure when enabled.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    end
  end

  // Wait (bounded) for done; returns the number of negedges observed since the start edge.
  task automatic wait_done(output int cycles);
    cycles = 0;
    while (1) begin
      @(negedge clk);
      cycles++;
      if (done) break;
      if (cycles > 2000) begin
        n_checks++; n_fail++;
        $display("FAIL wait_done: timeout after %0d cycles, expected done", cycles);
        break;
      end
    end
  endtask

  // Issue a start pulse at posedge+1 so it is sampled cleanly on the next edge.
  task automatic issue_start();
    @(posedge clk); #1;
    start = 1'b1;
    push_frame(params_flat);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_hs(input int target);
    int guard;
    guard = 0;
    while (hs_count < target && guard < 2000) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 2000) begin
      n_checks++; n_fail++;
      $display("FAIL wait_hs: handshake count %0d expected %0d", hs_count, target);
    end
  endtask

  task automatic set_params_inc();
    for (int k = 0; k < TOTAL; k++) params_flat[8*k +: 8] = 8'(k + 1);
  endtask

  int cyc;
  int base;

  initial begin
    // Reset state.
    #12;
    check("rst_data", out_data, 8'h00);
    check("rst_valid", out_valid, 1'b0);
    check("rst_last", out_last, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    @(negedge clk); #2 rst_n = 1'b1;

    // Test 1: incrementing bytes, sink always ready -> back-to-back frame.
    set_params_inc();
    out_ready = 1'b1;
    issue_start();
    wait_done(cyc);
    check("t1_cycles", cyc, FLEN + 1);
    check("t1_queue_empty", exp_q.size(), 0);

    // Test 2: same params with random backpressure.
    rand_ready = 1;
    issue_start();
    wait_done(cyc);
    rand_ready = 0; out_ready = 1'b1;
    check("t2_queue_empty", exp_q.size(), 0);

    // Test 3: overwrite params after the first handshake; frame uses the snapshot.
    base = hs_count;
    issue_start();
    wait_hs(base + 1);
    params_flat = {PW{1'b1}};
    wait_done(cyc);
    check("t3_queue_empty", exp_q.size(), 0);

    // Test 4: start during the payload and with the final handshake is ignored.
    set_params_inc();
    base = hs_count;
    issue_start();
    wait_hs(base + 6);
    start = 1'b1; @(posedge clk); #1 start = 1'b0;
    begin
      int g;
      g = 0;
      do begin @(negedge clk); g++; end while (!(out_valid && out_last) && g < 500);
    end
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("t4_no_restart", out_valid, 1'b0);
    end
    check("t4_queue_empty", exp_q.size(), 0);
    issue_start();
    wait_done(cyc);
    check("t4_fresh_cycles", cyc, FLEN + 1);

    // Test 5: async reset mid-payload aborts the frame.
    base = hs_count;
    issue_start();
    wait_hs(base + 11);
    @(negedge clk); #2 rst_n = 1'b0;
    #1;
    check("t5_rst_data", out_data, 8'h00);
    check("t5_rst_valid", out_valid, 1'b0);
    check("t5_rst_last", out_last, 1'b0);
    check("t5_rst_busy", busy, 1'b0);
    check("t5_rst_done", done, 1'b0);
    exp_q.delete();
    @(negedge clk); #2 rst_n = 1'b1;
    issue_start();
    wait_done(cyc);
    check("t5_full_cycles", cyc, FLEN + 1);
    check("t5_queue_empty", exp_q.size(), 0);

    // Test 6: constant 3C parameters.
    params_flat = {TOTAL{8'h3C}};
    issue_start();
    wait_done(cyc);
    check("t6_cycles", cyc, FLEN + 1);

    // Randomized frames with random parameters and backpressure.
    for (int f = 0; f < 8; f++) begin
      for (int k = 0; k < TOTAL; k++) params_flat[8*k +: 8] = 8'($urandom);
      rand_ready = (f % 2) == 1;
      issue_start();
      params_flat = {PW{1'b0}} ^ {TOTAL{8'($urandom)}};
      wait_done(cyc);
      rand_ready = 0; out_ready = 1'b1;
      check("rand_queue_empty", exp_q.size(), 0);
    end

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
